// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS run/dump debug controller.
// The checksum states exist only when DUMP_CHECKSUM_EN is defined.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DUMP_REG,
    ST_DUMP_MEM,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM_REG,
    ST_CSUM_MEM,
`endif
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] REGION_REG  = 2'd0;
  localparam logic [1:0] REGION_MEM  = 2'd1;
  localparam logic [1:0] REGION_CSUM = 2'd2;

endpackage

// File: rtl/mips_dbg_stream_reg.sv
// Valid/ready output register slice for the dump stream.
// Loads whenever it is empty or its word is being taken; holds under stall.
module mips_dbg_stream_reg #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [1:0]        in_region,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic [1:0]        out_region,
  output logic              out_last
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_region <= '0;
      out_last   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data   <= in_data;
        out_idx    <= in_idx;
        out_region <= in_region;
        out_last   <= in_last;
      end
    end
  end

endmodule

// File: rtl/mips_run_dump_ctrl.sv
// Run/dump controller: steps the core, then streams regfile and memory.
// Define DUMP_CHECKSUM_EN to append a per-region checksum word.
module mips_run_dump_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_DEPTH = 256,
  parameter int CYC_W     = 16,
  parameter int IDX_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic              cpu_halt,
  output logic              cpu_en,
  output logic [IDX_W-1:0]  reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [IDX_W-1:0]  mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic [1:0]        out_region,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  state_e            state, state_n;
  logic [CYC_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_region;
  logic              w_last;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum, csum_n;
`endif

  assign cpu_en    = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign reg_raddr = (state == ST_DUMP_REG) ? idx : '0;
  assign mem_raddr = (state == ST_DUMP_MEM) ? idx : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) csum <= '0;
    else       csum <= csum_n;
  end
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    w_valid  = 1'b0;
    w_data   = '0;
    w_idx    = idx;
    w_region = REGION_REG;
    w_last   = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_n   = csum;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_n = run_cycles;
          idx_n = '0;
`ifdef DUMP_CHECKSUM_EN
          csum_n = '0;
`endif
          state_n = (run_cycles == '0) ? ST_DUMP_REG : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_n = cnt - CYC_ONE;
        // the halting cycle itself is still an enabled cycle
        if (cnt == CYC_ONE || cpu_halt) begin
          idx_n   = '0;
          state_n = ST_DUMP_REG;
`ifdef DUMP_CHECKSUM_EN
          csum_n  = '0;
`endif
        end
      end
      ST_DUMP_REG: begin
        w_valid  = 1'b1;
        w_data   = reg_rdata;
        w_region = REGION_REG;
        if (w_ready) begin
`ifdef DUMP_CHECKSUM_EN
          csum_n = csum + reg_rdata;
`endif
          if (idx == REG_LAST) begin
            idx_n = '0;
`ifdef DUMP_CHECKSUM_EN
            state_n = ST_CSUM_REG;
`else
            state_n = ST_DUMP_MEM;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM_REG: begin
        w_valid  = 1'b1;
        w_data   = csum;
        w_idx    = '0;
        w_region = REGION_CSUM;
        if (w_ready) begin
          csum_n  = '0;
          idx_n   = '0;
          state_n = ST_DUMP_MEM;
        end
      end
`endif
      ST_DUMP_MEM: begin
        w_valid  = 1'b1;
        w_data   = mem_rdata;
        w_region = REGION_MEM;
`ifndef DUMP_CHECKSUM_EN
        w_last   = (idx == MEM_LAST);
`endif
        if (w_ready) begin
`ifdef DUMP_CHECKSUM_EN
          csum_n = csum + mem_rdata;
`endif
          if (idx == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
            state_n = ST_CSUM_MEM;
`else
            state_n = ST_DRAIN;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM_MEM: begin
        w_valid  = 1'b1;
        w_data   = csum;
        w_idx    = IDX_W'(1);
        w_region = REGION_CSUM;
        w_last   = 1'b1;
        if (w_ready) state_n = ST_DRAIN;
      end
`endif
      ST_DRAIN: begin
        if (out_valid && out_ready) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  mips_dbg_stream_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (w_valid),
    .in_ready   (w_ready),
    .in_data    (w_data),
    .in_idx     (w_idx),
    .in_region  (w_region),
    .in_last    (w_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_region (out_region),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_mips_run_dump_ctrl.sv
// Scoreboard bench for mips_run_dump_ctrl.
// Build with DUMP_CHECKSUM_EN defined to cover the checksum words.
module tb_mips_run_dump_ctrl;
  import mips_dbg_pkg::*;

  localparam int DW = 32;
  localparam int RC = 32;
  localparam int MD = 256;
  localparam int CW = 16;
  localparam int IW = 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int NW = RC + MD + 2;
`else
  localparam int NW = RC + MD;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] run_cycles;
  logic          cpu_halt;
  logic          cpu_en;
  logic [IW-1:0] reg_raddr;
  logic [DW-1:0] reg_rdata;
  logic [IW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic [1:0]    out_region;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [RC];
  logic [DW-1:0] dm [MD];

  assign reg_rdata = rf[reg_raddr[4:0]];
  assign mem_rdata = dm[mem_raddr];

  mips_run_dump_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_cycles (run_cycles),
    .cpu_halt   (cpu_halt),
    .cpu_en     (cpu_en),
    .reg_raddr  (reg_raddr),
    .reg_rdata  (reg_rdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_region (out_region),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic [1:0]    region;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   en_cycles = 0;
  int   done_pulses = 0;
  int   valid_cycles = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_dump();
    logic [DW-1:0] rs;
    logic [DW-1:0] ms;
    rs = '0;
    ms = '0;
    for (int k = 0; k < RC; k++) begin
      q.push_back('{rf[k], IW'(k), REGION_REG, 1'b0});
      rs += rf[k];
    end
`ifdef DUMP_CHECKSUM_EN
    q.push_back('{rs, IW'(0), REGION_CSUM, 1'b0});
`endif
    for (int k = 0; k < MD; k++) begin
      ms += dm[k];
`ifdef DUMP_CHECKSUM_EN
      q.push_back('{dm[k], IW'(k), REGION_MEM, 1'b0});
`else
      q.push_back('{dm[k], IW'(k), REGION_MEM, k == MD - 1});
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    q.push_back('{ms, IW'(1), REGION_CSUM, 1'b1});
`endif
  endtask

  task automatic clr_counts();
    en_cycles = 0;
    done_pulses = 0;
    valid_cycles = 0;
  endtask

  task automatic do_start(input int n);
    @(posedge clock);
    #1;
    start = 1'b1;
    run_cycles = CW'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 5000) begin
      @(negedge clock);
      k++;
    end
    chk({nm, "_done_timeout"}, 64'(k < 5000), 64'd1);
    @(negedge clock);
    chk({nm, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({nm, "_done_pulses"}, 64'(done_pulses), 64'd1);
    chk({nm, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {out_data, out_idx, out_region, out_last, out_valid,
             cpu_en, busy, done, reg_raddr, mem_raddr}, 64'd0);
  endtask

  // ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pops on each transfer, checks hold under stall
  initial begin
    exp_t e;
    exp_t cur;
    exp_t prev;
    bit   stall;
    stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (cpu_en) en_cycles++;
        if (done) done_pulses++;
        if (out_valid) valid_cycles++;
        cur = '{out_data, out_idx, out_region, out_last};
        if (stall) chk("stall_hold", 64'(cur), 64'(prev));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("extra_word", 64'(cur), 64'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("word_r%0d_i%0d", e.region, e.idx),
                64'(cur), 64'(e));
          end
        end
        stall = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    reset = 1'b1;
    start = 1'b0;
    run_cycles = '0;
    cpu_halt = 1'b0;
    for (int i = 0; i < RC; i++) rf[i] = 32'hA500_0000 + 32'(i * 3);
    for (int i = 0; i < MD; i++) dm[i] = 32'h1234_0000 ^ 32'(i * 257);
    #1;
    chk_zero("reset_state");
    #20;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // full run of 10 cycles, continuous sink
    clr_counts();
    push_dump();
    do_start(10);
    @(negedge clock);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done("run10");
    chk("run10_en_cycles", 64'(en_cycles), 64'd10);
    chk("run10_valid_cycles", 64'(valid_cycles), 64'(NW));

    // halt on enabled cycle 7 of a 100-cycle budget
    clr_counts();
    push_dump();
    do_start(100);
    seen = 0;
    for (int i = 0; i < 300 && seen < 7; i++) begin
      if (cpu_en) seen++;
      if (seen < 7) begin
        @(posedge clock);
        #1;
      end
    end
    cpu_halt = 1'b1;
    @(posedge clock);
    #1;
    cpu_halt = 1'b0;
    chk("halt_en_drops", 64'(cpu_en), 64'd0);
    @(posedge clock);
    #1;
    chk("halt_dump_starts", {61'd0, out_valid, out_region},
        {61'd0, 1'b1, REGION_REG});
    wait_done("halt");
    chk("halt_en_cycles", 64'(en_cycles), 64'd7);

    // zero budget: straight to dump
    clr_counts();
    push_dump();
    do_start(0);
    k = 0;
    while (out_valid !== 1'b1 && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("zero_first_valid_le2", 64'(k <= 2), 64'd1);
    wait_done("zero");
    chk("zero_en_cycles", 64'(en_cycles), 64'd0);

    // pseudo-random backpressure
    clr_counts();
    rand_ready = 1'b1;
    push_dump();
    do_start(3);
    wait_done("rand");
    rand_ready = 1'b0;

    // async reset in the middle of the memory dump
    clr_counts();
    push_dump();
    do_start(2);
    k = 0;
    while (!(out_valid === 1'b1 && out_region == REGION_MEM &&
             out_idx == 8'd40) && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk("reach_mem40", 64'(k < 1000), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("midreset_zero");
    q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    clr_counts();
    push_dump();
    do_start(0);
    wait_done("after_reset");

    // sparse regfile: reg checksum would be 5+7
    for (int i = 0; i < RC; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    clr_counts();
    push_dump();
    do_start(1);
    wait_done("sparse");
    chk("sparse_en_cycles", 64'(en_cycles), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
